// File: rtl/dmem_port_arbiter.sv
// Shares the single data-memory port between the core load/store path (m0) and
// a loader/DMA port (m1) using round-robin ownership with a per-owner hold limit.
module dmem_port_arbiter #(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int MAX_HOLD = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_gnt,
    output logic          m0_stall,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_gnt,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic [DW-1:0] rdata
);

    localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HW-1:0] HOLD_SAT = HW'(MAX_HOLD - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic          last_q, last_d;
    logic [HW-1:0] hold_q, hold_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            hold_q  <= hold_d;
        end
    end

    // last_q names the most recent owner; a tie in IDLE goes to the other one.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        hold_d  = hold_q;
        unique case (state_q)
            IDLE: begin
                hold_d = '0;
                if (m0_req && m1_req) begin
                    state_d = last_q ? OWN0 : OWN1;
                    last_d  = ~last_q;
                end else if (m0_req) begin
                    state_d = OWN0;
                    last_d  = 1'b0;
                end else if (m1_req) begin
                    state_d = OWN1;
                    last_d  = 1'b1;
                end
            end
            OWN0: begin
                if (!m0_req) begin
                    hold_d = '0;
                    if (m1_req) begin
                        state_d = OWN1;
                        last_d  = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (m1_req && (hold_q == HOLD_SAT)) begin
                    state_d = OWN1;
                    last_d  = 1'b1;
                    hold_d  = '0;
                end else if (hold_q != HOLD_SAT) begin
                    hold_d = hold_q + HW'(1);
                end
            end
            OWN1: begin
                if (!m1_req) begin
                    hold_d = '0;
                    if (m0_req) begin
                        state_d = OWN0;
                        last_d  = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (m0_req && (hold_q == HOLD_SAT)) begin
                    state_d = OWN0;
                    last_d  = 1'b0;
                    hold_d  = '0;
                end else if (hold_q != HOLD_SAT) begin
                    hold_d = hold_q + HW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                hold_d  = '0;
            end
        endcase
    end

    // Port mux follows the registered owner so ungranted requests never reach dmem.
    always_comb begin
        m0_gnt    = (state_q == OWN0);
        m1_gnt    = (state_q == OWN1);
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (state_q == OWN0) begin
            mem_we    = m0_we & m0_req;
            mem_addr  = m0_addr;
            mem_wdata = m0_wdata;
        end else if (state_q == OWN1) begin
            mem_we    = m1_we & m1_req;
            mem_addr  = m1_addr;
            mem_wdata = m1_wdata;
        end
    end

    // Stall is forced low while reset is held so the core sees a quiet port.
    assign m0_stall = m0_req & ~m0_gnt & reset;
    assign rdata    = mem_rdata;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Self-checking bench for dmem_port_arbiter: a per-cycle vector table from reset,
// plus hand-written sequences for write commit, hold preemption and mid-write reset.
module tb_dmem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk;
    logic          reset;
    logic          m0Req, m0We, m1Req, m1We;
    logic [AW-1:0] m0Addr, m1Addr;
    logic [DW-1:0] m0Wdata, m1Wdata;
    logic          m0Gnt, m0Stall, m1Gnt;
    logic          memWe;
    logic [AW-1:0] memAddr;
    logic [DW-1:0] memWdata, memRdata, rdata;

    logic [DW-1:0] dmem [0:63];

    int testsRun = 0;
    int testsFailed = 0;

    typedef struct {
        logic r0, w0, r1, w1;
        logic g0, g1, s0, we;
    } vec_t;

    vec_t vecs[$];

    dmem_port_arbiter #(.AW(AW), .DW(DW), .MAX_HOLD(4)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0Req), .m0_we(m0We), .m0_addr(m0Addr), .m0_wdata(m0Wdata),
        .m0_gnt(m0Gnt), .m0_stall(m0Stall),
        .m1_req(m1Req), .m1_we(m1We), .m1_addr(m1Addr), .m1_wdata(m1Wdata),
        .m1_gnt(m1Gnt),
        .mem_we(memWe), .mem_addr(memAddr), .mem_wdata(memWdata),
        .mem_rdata(memRdata), .rdata(rdata)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural dmem: combinational read, write on the rising edge.
    assign memRdata = dmem[memAddr[7:2]];
    always @(posedge clk) begin
        if (memWe) dmem[memAddr[7:2]] <= memWdata;
    end

    // Hard stop in case a sequence never returns.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic applyStimulus(input logic r0, input logic w0, input logic r1, input logic w1);
        m0Req = r0;
        m0We  = w0;
        m1Req = r1;
        m1We  = w1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic addVec(input logic r0, w0, r1, w1, g0, g1, s0, we);
        vec_t v;
        v.r0 = r0; v.w0 = w0; v.r1 = r1; v.w1 = w1;
        v.g0 = g0; v.g1 = g1; v.s0 = s0; v.we = we;
        vecs.push_back(v);
    endtask

    initial begin
        logic [AW-1:0] expAddr;
        logic [DW-1:0] expWdata;
        int stallCount;

        for (int i = 0; i < 64; i++) dmem[i] = '0;

        // Inputs r0 w0 r1 w1 | expected g0 g1 s0 we, one entry per cycle after reset.
        addVec(1,0,1,0, 0,0,1,0);
        addVec(1,0,1,0, 1,0,0,0);
        addVec(1,0,1,0, 1,0,0,0);
        addVec(1,0,1,0, 1,0,0,0);
        addVec(1,0,1,0, 1,0,0,0);
        addVec(1,0,1,0, 0,1,1,0);
        addVec(1,0,1,0, 0,1,1,0);
        addVec(1,0,1,0, 0,1,1,0);
        addVec(1,0,1,0, 0,1,1,0);
        addVec(1,1,1,1, 1,0,0,1);
        addVec(0,1,1,1, 1,0,0,0);
        addVec(1,0,0,1, 0,1,1,0);
        addVec(1,0,0,1, 1,0,0,0);
        addVec(0,0,0,0, 1,0,0,0);
        addVec(1,0,0,0, 0,0,1,0);
        addVec(1,1,0,0, 1,0,0,1);
        addVec(0,0,0,0, 1,0,0,0);
        addVec(0,0,0,0, 0,0,0,0);
        addVec(1,0,1,0, 0,0,1,0);
        addVec(1,0,1,0, 0,1,1,0);
        addVec(0,0,0,0, 0,1,0,0);
        addVec(0,0,0,0, 0,0,0,0);

        m0Addr = 32'h10; m0Wdata = 32'hA5A5_0000;
        m1Addr = 32'h20; m1Wdata = 32'h5A5A_1111;

        // Reset held for two cycles with both requesting: nothing granted.
        reset = 1'b0;
        applyStimulus(1, 0, 1, 0);
        nextCycle();
        nextCycle();
        checkOutput("rst_gnt0", 32'(m0Gnt), 32'd0);
        checkOutput("rst_gnt1", 32'(m1Gnt), 32'd0);
        checkOutput("rst_we", 32'(memWe), 32'd0);
        checkOutput("rst_stall", 32'(m0Stall), 32'd0);
        checkOutput("rst_addr", memAddr, 32'd0);
        reset = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].r0, vecs[i].w0, vecs[i].r1, vecs[i].w1);
            @(negedge clk);
            expAddr  = vecs[i].g0 ? m0Addr : (vecs[i].g1 ? m1Addr : 32'd0);
            expWdata = vecs[i].g0 ? m0Wdata : (vecs[i].g1 ? m1Wdata : 32'd0);
            checkOutput($sformatf("vec%0d_gnt0", i), 32'(m0Gnt), 32'(vecs[i].g0));
            checkOutput($sformatf("vec%0d_gnt1", i), 32'(m1Gnt), 32'(vecs[i].g1));
            checkOutput($sformatf("vec%0d_stall", i), 32'(m0Stall), 32'(vecs[i].s0));
            checkOutput($sformatf("vec%0d_we", i), 32'(memWe), 32'(vecs[i].we));
            checkOutput($sformatf("vec%0d_addr", i), memAddr, expAddr);
            checkOutput($sformatf("vec%0d_wdata", i), memWdata, expWdata);
            checkOutput($sformatf("vec%0d_rdata", i), rdata, dmem[expAddr[7:2]]);
            nextCycle();
        end
        checkOutput("tbl_commit_m0", dmem[32'h10 >> 2], 32'hA5A5_0000);
        checkOutput("tbl_m1_never_wrote", dmem[32'h20 >> 2], 32'd0);

        // Lone m0 write of 25 to 0x60: one stall cycle, then commit.
        m0Addr = 32'h60; m0Wdata = 32'd25;
        applyStimulus(1, 1, 0, 0);
        stallCount = 0;
        @(negedge clk);
        stallCount += int'(m0Stall);
        checkOutput("wr_wait_gnt0", 32'(m0Gnt), 32'd0);
        nextCycle();
        @(negedge clk);
        stallCount += int'(m0Stall);
        checkOutput("wr_gnt0", 32'(m0Gnt), 32'd1);
        checkOutput("wr_we", 32'(memWe), 32'd1);
        checkOutput("wr_addr", memAddr, 32'h60);
        nextCycle();
        checkOutput("wr_commit", dmem[32'h60 >> 2], 32'd25);
        checkOutput("wr_stall_cycles", 32'(stallCount), 32'd1);
        applyStimulus(1, 0, 0, 0);
        @(negedge clk);
        checkOutput("rd_rdata", rdata, 32'd25);
        nextCycle();
        applyStimulus(0, 0, 0, 0);
        nextCycle();
        nextCycle();

        // m1 alone for ten cycles; m0 joins at cycle 6 and wins at cycle 7.
        reset = 1'b0;
        #1;
        reset = 1'b1;
        stallCount = 0;
        for (int k = 0; k < 10; k++) begin
            applyStimulus(k >= 6, 1'b0, 1'b1, 1'b0);
            @(negedge clk);
            stallCount += int'(m0Stall);
            checkOutput($sformatf("hold%0d_gnt1", k), 32'(m1Gnt), 32'(k >= 1 && k <= 6));
            checkOutput($sformatf("hold%0d_gnt0", k), 32'(m0Gnt), 32'(k >= 7));
            nextCycle();
        end
        checkOutput("hold_stall_cycles", 32'(stallCount), 32'd1);

        // Reset mid-write in OWN0 drops grant and write before the next edge.
        applyStimulus(0, 0, 0, 0);
        nextCycle();
        nextCycle();
        m0Wdata = 32'd77;
        applyStimulus(1, 1, 0, 0);
        nextCycle();
        checkOutput("mid_pre_we", 32'(memWe), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("mid_gnt0", 32'(m0Gnt), 32'd0);
        checkOutput("mid_we", 32'(memWe), 32'd0);
        checkOutput("mid_addr", memAddr, 32'd0);
        checkOutput("mid_stall", 32'(m0Stall), 32'd0);
        nextCycle();
        checkOutput("mid_no_commit", dmem[32'h60 >> 2], 32'd25);
        reset = 1'b1;
        applyStimulus(1, 0, 1, 0);
        @(negedge clk);
        checkOutput("post_idle_gnt0", 32'(m0Gnt), 32'd0);
        nextCycle();
        @(negedge clk);
        checkOutput("post_tie_gnt0", 32'(m0Gnt), 32'd1);
        checkOutput("post_tie_gnt1", 32'(m1Gnt), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
